// File: rtl/motor_soft_start.sv
// Purpose: rate-limits speed commands and only reverses direction at zero speed after a dead time.
// Latency: first effect of an input change appears on the next ramp tick (at most TICK_DIV cycles).
// Backpressure: none; inputs are level commands sampled on ramp ticks, outputs are always valid.
//
// Ports:
//   clk          - system clock
//   rst          - synchronous reset, active-high
//   target_speed - commanded speed (WIDTH bits)
//   target_dir   - commanded direction, 1 = forward
//   speed_out    - ramped speed to the PWM stage
//   dir_out      - direction to the H-bridge stage
//   busy         - high while ramping down for a reversal or waiting out the dead time
//   at_target    - combinational; speed_out and dir_out both match the command
//   estop        - only with MOTOR_SOFT_START_ESTOP_EN defined: immediate stop into dead time
//
// Optional feature macro: MOTOR_SOFT_START_ESTOP_EN

module motor_soft_start #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] STEP       = 8'd5,
  parameter logic [27:0]      TICK_DIV   = 28'd12000,
  parameter logic [7:0]       DEAD_TICKS = 8'd50
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MOTOR_SOFT_START_ESTOP_EN
  input  logic             estop,
`endif
  input  logic [WIDTH-1:0] target_speed,
  input  logic             target_dir,
  output logic [WIDTH-1:0] speed_out,
  output logic             dir_out,
  output logic             busy,
  output logic             at_target
);

  typedef enum logic [1:0] {
    TRACK     = 2'd0,
    RAMP_DOWN = 2'd1,
    DEAD      = 2'd2
  } state_t;

  // A zero divider or zero dead time degenerates to one cycle / one tick.
  localparam logic [27:0] TICK_LAST = (TICK_DIV == 28'd0) ? 28'd0 : TICK_DIV - 28'd1;
  localparam logic [7:0]  DEAD_LAST = (DEAD_TICKS == 8'd0) ? 8'd0 : DEAD_TICKS - 8'd1;

  logic [27:0]      presc_q, presc_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] speed_q, speed_d;
  logic             dir_q, dir_d;
  logic [7:0]       dead_q, dead_d;
  logic             busy_q;
  logic             tick;

  // Gaps are computed one bit wider so the comparisons against STEP can
  // never wrap and the ramp can never overshoot the target.
  logic [WIDTH:0]   speed_x, tgt_x, step_x, up_gap, dn_gap;

  assign tick    = (presc_q == TICK_LAST);
  assign speed_x = {1'b0, speed_q};
  assign tgt_x   = {1'b0, target_speed};
  assign step_x  = {1'b0, STEP};
  assign up_gap  = tgt_x - speed_x;
  assign dn_gap  = speed_x - tgt_x;

  always_comb begin
    presc_d = tick ? 28'd0 : presc_q + 28'd1;
    state_d = state_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    dead_d  = dead_q;

    if (tick) begin
      case (state_q)
        TRACK: begin
          if (target_dir != dir_q) begin
            // Speed is left alone on the tick that detects a reversal.
            state_d = RAMP_DOWN;
          end else if (speed_q < target_speed) begin
            speed_d = (up_gap > step_x) ? speed_q + STEP : target_speed;
          end else if (speed_q > target_speed) begin
            speed_d = (dn_gap > step_x) ? speed_q - STEP : target_speed;
          end
        end

        RAMP_DOWN: begin
          if (target_dir == dir_q) begin
            // Reversal withdrawn: resume tracking from the current speed.
            state_d = TRACK;
          end else if (speed_x > step_x) begin
            speed_d = speed_q - STEP;
          end else begin
            speed_d = '0;
            state_d = DEAD;
            dead_d  = 8'd0;
          end
        end

        DEAD: begin
          speed_d = '0;
          if (dead_q == DEAD_LAST) begin
            // Direction is taken from the command as it stands now, even if
            // that rewrites the same value after a reverted request.
            dir_d   = target_dir;
            state_d = TRACK;
          end else begin
            dead_d = dead_q + 8'd1;
          end
        end

        default: begin
          state_d = TRACK;
          speed_d = '0;
        end
      endcase
    end

`ifdef MOTOR_SOFT_START_ESTOP_EN
    // Emergency stop acts every cycle, not just on ticks, and holds the
    // dead counter cleared for as long as it is asserted.
    if (estop) begin
      speed_d = '0;
      state_d = DEAD;
      dead_d  = 8'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 28'd0;
      state_q <= TRACK;
      speed_q <= '0;
      dir_q   <= 1'b1;
      dead_q  <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      busy_q  <= (state_d != TRACK);
    end
  end

  assign speed_out = speed_q;
  assign dir_out   = dir_q;
  assign busy      = busy_q;
  assign at_target = (speed_q == target_speed) && (dir_q == target_dir);

endmodule

// File: tb/tb_motor_soft_start.sv
// Purpose: scoreboard bench for motor_soft_start with TICK_DIV=4, STEP=5, DEAD_TICKS=3.
// Latency: expectations are compared one ramp tick (4 clk edges) after each is queued.
// Backpressure: not applicable; the DUT has no handshake.

module tb_motor_soft_start;

  logic       clk;
  logic       rst;
  logic [7:0] target_speed;
  logic       target_dir;
  logic [7:0] speed_out;
  logic       dir_out;
  logic       busy;
  logic       at_target;
`ifdef MOTOR_SOFT_START_ESTOP_EN
  logic       estop;
`endif

  typedef struct {
    logic [7:0] spd;
    logic       dir;
    logic       bsy;
    logic       at;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  motor_soft_start #(
    .WIDTH      (8),
    .STEP       (8'd5),
    .TICK_DIV   (28'd4),
    .DEAD_TICKS (8'd3)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
`ifdef MOTOR_SOFT_START_ESTOP_EN
    .estop        (estop),
`endif
    .target_speed (target_speed),
    .target_dir   (target_dir),
    .speed_out    (speed_out),
    .dir_out      (dir_out),
    .busy         (busy),
    .at_target    (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] spd, input logic dir, input logic bsy, input logic at);
    exp_t e;
    e.spd = spd;
    e.dir = dir;
    e.bsy = bsy;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  // Advance n edges to the next ramp tick and compare against the oldest expectation.
  task automatic tick_check(input int n);
    exp_t e;
    repeat (n) @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("speed_out", {24'd0, speed_out}, {24'd0, e.spd});
      chk("dir_out",   {31'd0, dir_out},   {31'd0, e.dir});
      chk("busy",      {31'd0, busy},      {31'd0, e.bsy});
      chk("at_target", {31'd0, at_target}, {31'd0, e.at});
    end
  endtask

  task automatic drain();
    while (exp_q.size() != 0) tick_check(4);
  endtask

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    target_speed = 8'd200;
    target_dir   = 1'b1;
`ifdef MOTOR_SOFT_START_ESTOP_EN
    estop        = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_speed", {24'd0, speed_out}, 32'd0);
    chk("rst_dir",   {31'd0, dir_out},   32'd1);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_at",    {31'd0, at_target}, 32'd0);
    rst          = 1'b0;
    target_speed = 8'd12;

    // Ramp up: nothing moves until the 4th edge after reset release.
    repeat (3) @(posedge clk);
    #1;
    chk("pre_tick_speed", {24'd0, speed_out}, 32'd0);
    push(8'd5, 1'b1, 1'b0, 1'b0);
    tick_check(1);
    push(8'd10, 1'b1, 1'b0, 1'b0);
    push(8'd12, 1'b1, 1'b0, 1'b1);
    push(8'd12, 1'b1, 1'b0, 1'b1);
    drain();

    // Ramp down with no undershoot below target 0.
    target_speed = 8'd0;
    push(8'd7, 1'b1, 1'b0, 1'b0);
    push(8'd2, 1'b1, 1'b0, 1'b0);
    push(8'd0, 1'b1, 1'b0, 1'b1);
    drain();

    // Bring speed to 10 forward, then request reverse.
    target_speed = 8'd10;
    push(8'd5,  1'b1, 1'b0, 1'b0);
    push(8'd10, 1'b1, 1'b0, 1'b1);
    drain();
    target_dir = 1'b0;
    push(8'd10, 1'b1, 1'b1, 1'b0);  // enter RAMP_DOWN, no adjustment
    push(8'd5,  1'b1, 1'b1, 1'b0);
    push(8'd0,  1'b1, 1'b1, 1'b0);  // reaches zero, enters DEAD
    push(8'd0,  1'b1, 1'b1, 1'b0);  // dead tick 1
    push(8'd0,  1'b1, 1'b1, 1'b0);  // dead tick 2
    push(8'd0,  1'b0, 1'b0, 1'b0);  // dead tick 3: direction flips
    push(8'd5,  1'b0, 1'b0, 1'b0);
    push(8'd10, 1'b0, 1'b0, 1'b1);
    drain();

    // Cancelled reversal: request forward, then withdraw at speed 5.
    target_dir = 1'b1;
    push(8'd10, 1'b0, 1'b1, 1'b0);
    push(8'd5,  1'b0, 1'b1, 1'b0);
    drain();
    target_dir = 1'b0;
    push(8'd5,  1'b0, 1'b0, 1'b0);
    push(8'd10, 1'b0, 1'b0, 1'b1);
    drain();

`ifdef MOTOR_SOFT_START_ESTOP_EN
    target_speed = 8'd50;
    for (int s = 15; s <= 50; s += 5)
      push(8'(s), 1'b0, 1'b0, (s == 50) ? 1'b1 : 1'b0);
    drain();
    // One-cycle estop pulse between ticks.
    @(posedge clk);
    #1;
    estop = 1'b1;
    @(posedge clk);
    #1;
    estop = 1'b0;
    chk("estop_speed", {24'd0, speed_out}, 32'd0);
    chk("estop_busy",  {31'd0, busy},      32'd1);
    push(8'd0, 1'b0, 1'b1, 1'b0);
    tick_check(2);
    push(8'd0, 1'b0, 1'b1, 1'b0);
    push(8'd0, 1'b0, 1'b0, 1'b0);
    push(8'd5, 1'b0, 1'b0, 1'b0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
